ram_word_loader: RTL

- Upstream write-feeder for the 8-word / 16K RAM stack.
- Takes a byte stream over a valid/ready handshake and pairs bytes into 16-bit words, low byte first.
- Writes each word into RAM at consecutive addresses, starting from a programmed base address.
- Drives the RAM's in/load/address pins directly; used at boot to preload program/data memory.

---
 rtl/ram_word_loader.sv | 121 ++++++++++++
 1 files changed

// File: rtl/ram_word_loader.sv
// Boot-time RAM preloader: pairs a valid/ready byte stream (low byte first) into
// 16-bit words and writes them to consecutive RAM addresses from a base address.
//
// state | meaning
// IDLE  | waiting for start
// LO    | waiting for the low byte of the current word
// HI    | waiting for the high byte of the current word
// WRITE | ram_load high, RAM captures the word on the edge leaving this state
// DONE  | one-cycle done pulse, back to IDLE next
module ram_word_loader #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  abort,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic [DATA_WIDTH-1:0] ram_in,
    output logic                  ram_load,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LO    = 3'd1,
        HI    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_cnt;
    logic [ADDR_WIDTH:0]   remaining;
    logic [7:0]            low_byte;
    logic                  accept;

    assign byte_ready = (state == LO) || (state == HI);
    assign accept     = byte_valid && byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_cnt    <= '0;
            remaining   <= '0;
            low_byte    <= '0;
            ram_in      <= '0;
            ram_load    <= 1'b0;
            ram_address <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            ram_load <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        busy <= 1'b1;
                        if (word_count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            addr_cnt  <= base_addr;
                            remaining <= word_count;
                            state     <= LO;
                        end
                    end
                end
                LO: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        low_byte <= byte_data;
                        state    <= HI;
                    end
                end
                HI: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (accept) begin
                        ram_in      <= {byte_data, low_byte};
                        ram_address <= addr_cnt;
                        ram_load    <= 1'b1;
                        state       <= WRITE;
                    end
                end
                WRITE: begin
                    // The write itself cannot be cancelled; abort only skips the rest.
                    addr_cnt  <= addr_cnt + ADDR_WIDTH'(1);
                    remaining <= remaining - (ADDR_WIDTH + 1)'(1);
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (remaining == (ADDR_WIDTH + 1)'(1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= LO;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
